// File: rtl/phy_mgmt_sched.sv
// -----------------------------------------------------------------------------
// phy_mgmt_sched
//
// Purpose:
//   Brings up four PHYs that share one hardware reset and one MDIO engine.
//   The sequence is:
//     1. Hold the PHY reset low.
//     2. Wait for the PHYs to settle.
//     3. Write the configuration register of each PHY in turn.
//     4. Poll the status register of each PHY round-robin, forever.
//   Each poll updates the per-port link status.
//   Every MDIO transaction is guarded by a timeout. A timed-out transaction
//   sets a sticky error flag and the sequence advances anyway.
//
// Ports:
//   clk         in   1   sole clock
//   rst_n       in   1   asynchronous active-low reset
//   restart     in   1   single-cycle pulse: re-run the whole sequence
//   phy_rst_n   out  1   shared PHY hardware reset, active low
//   mdio_req    out  1   transaction request to the MDIO engine
//   mdio_rd     out  1   1 = read, 0 = write
//   mdio_phy    out  5   PHY address
//   mdio_reg    out  5   register address
//   mdio_wdata  out  16  write data
//   mdio_ack    in   1   single-cycle completion pulse from the engine
//   mdio_rdata  in   16  read data, valid with mdio_ack
//   link_up     out  4   per-port link status
//   cfg_done    out  1   all four configuration writes completed
//   err         out  1   sticky: at least one transaction timed out
// -----------------------------------------------------------------------------
module phy_mgmt_sched #(
   parameter int unsigned RST_HOLD_CYC  = 1250000,
   parameter int unsigned RST_WAIT_CYC  = 625000,
   parameter int unsigned POLL_GAP_CYC  = 12500,
   parameter int unsigned TIMEOUT_CYC   = 65535,
   parameter logic [4:0]  PHY_ADDR_BASE = 5'd0,
   parameter logic [4:0]  CFG_REG       = 5'd20,
   parameter logic [15:0] CFG_DATA      = 16'h0CE2,
   parameter logic [4:0]  STAT_REG      = 5'd1,
   parameter int unsigned LINK_BIT      = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        restart,
   output logic        phy_rst_n,
   output logic        mdio_req,
   output logic        mdio_rd,
   output logic [4:0]  mdio_phy,
   output logic [4:0]  mdio_reg,
   output logic [15:0] mdio_wdata,
   input  logic        mdio_ack,
   input  logic [15:0] mdio_rdata,
   output logic [3:0]  link_up,
   output logic        cfg_done,
   output logic        err
);

   // One shared counter serves every phase, so it is sized for the largest phase.
   localparam int unsigned MAX_HW  = (RST_HOLD_CYC > RST_WAIT_CYC) ? RST_HOLD_CYC : RST_WAIT_CYC;
   localparam int unsigned MAX_GT  = (POLL_GAP_CYC > TIMEOUT_CYC) ? POLL_GAP_CYC : TIMEOUT_CYC;
   localparam int unsigned MAX_CYC = (MAX_HW > MAX_GT) ? MAX_HW : MAX_GT;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

   // Terminal counts: a phase lasting N cycles ends when the counter shows N-1.
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RST_WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(POLL_GAP_CYC - 1);
   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

   localparam logic [15:0] LINK_MASK = 16'd1 << LINK_BIT;

   typedef enum logic [2:0] {
      StRstHold,
      StRstWait,
      StCfg,
      StPollGap,
      StPoll
   } state_e;

   state_e           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_port;
   logic             r_phy_rst_n;
   logic             r_mdio_req;
   logic             r_mdio_rd;
   logic [4:0]       r_mdio_phy;
   logic [4:0]       r_mdio_reg;
   logic [15:0]      r_mdio_wdata;
   logic [3:0]       r_link_up;
   logic             r_cfg_done;
   logic             r_err;

   logic [4:0]       w_phy_addr;
   logic             w_link_bit;
   logic             w_tmo;

   // Adding into a 5-bit result gives the required modulo-32 wrap.
   assign w_phy_addr = PHY_ADDR_BASE + {3'b000, r_port};
   // Masking rather than indexing keeps the whole read-data bus in use.
   assign w_link_bit = |(mdio_rdata & LINK_MASK);
   // Only meaningful while a request is outstanding; the counter restarts at each issue.
   assign w_tmo      = (r_cnt == TMO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= StRstHold;
         r_cnt        <= '0;
         r_port       <= '0;
         r_phy_rst_n  <= 1'b0;
         r_mdio_req   <= 1'b0;
         r_mdio_rd    <= 1'b0;
         r_mdio_phy   <= '0;
         r_mdio_reg   <= '0;
         r_mdio_wdata <= '0;
         r_link_up    <= '0;
         r_cfg_done   <= 1'b0;
         r_err        <= 1'b0;
      end else if (restart) begin
         // Abandon everything except the sticky error.
         // Acks that arrive later are ignored because no request is outstanding.
         r_state      <= StRstHold;
         r_cnt        <= '0;
         r_port       <= '0;
         r_phy_rst_n  <= 1'b0;
         r_mdio_req   <= 1'b0;
         r_mdio_rd    <= 1'b0;
         r_mdio_phy   <= '0;
         r_mdio_reg   <= '0;
         r_mdio_wdata <= '0;
         r_link_up    <= '0;
         r_cfg_done   <= 1'b0;
      end else begin
         case (r_state)
            StRstHold: begin
               if (r_cnt == HOLD_LAST) begin
                  r_state     <= StRstWait;
                  r_cnt       <= '0;
                  r_phy_rst_n <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            StRstWait: begin
               if (r_cnt == WAIT_LAST) begin
                  r_state <= StCfg;
                  r_cnt   <= '0;
                  r_port  <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            StCfg: begin
               if (!r_mdio_req) begin
                  // Request idle: issue the write.
                  // Each completion drops req for a cycle first, which guarantees a gap.
                  r_mdio_req   <= 1'b1;
                  r_mdio_rd    <= 1'b0;
                  r_mdio_phy   <= w_phy_addr;
                  r_mdio_reg   <= CFG_REG;
                  r_mdio_wdata <= CFG_DATA;
                  r_cnt        <= '0;
               end else if (mdio_ack || w_tmo) begin
                  // Ack takes priority over a simultaneous timeout.
                  r_mdio_req <= 1'b0;
                  if (!mdio_ack) begin
                     r_err <= 1'b1;
                  end
                  if (r_port == 2'd3) begin
                     r_cfg_done <= 1'b1;
                     r_port     <= '0;
                     r_state    <= StPollGap;
                     r_cnt      <= '0;
                  end else begin
                     r_port <= r_port + 2'd1;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            StPollGap: begin
               if (r_cnt == GAP_LAST) begin
                  r_state <= StPoll;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            StPoll: begin
               if (!r_mdio_req) begin
                  r_mdio_req   <= 1'b1;
                  r_mdio_rd    <= 1'b1;
                  r_mdio_phy   <= w_phy_addr;
                  r_mdio_reg   <= STAT_REG;
                  r_mdio_wdata <= '0;
                  r_cnt        <= '0;
               end else if (mdio_ack || w_tmo) begin
                  // A timed-out poll reports the link as down.
                  r_mdio_req        <= 1'b0;
                  r_link_up[r_port] <= mdio_ack ? w_link_bit : 1'b0;
                  if (!mdio_ack) begin
                     r_err <= 1'b1;
                  end
                  r_port  <= r_port + 2'd1;
                  r_state <= StPollGap;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            default: begin
               r_state     <= StRstHold;
               r_cnt       <= '0;
               r_port      <= '0;
               r_phy_rst_n <= 1'b0;
               r_mdio_req  <= 1'b0;
            end
         endcase
      end
   end

   assign phy_rst_n  = r_phy_rst_n;
   assign mdio_req   = r_mdio_req;
   assign mdio_rd    = r_mdio_rd;
   assign mdio_phy   = r_mdio_phy;
   assign mdio_reg   = r_mdio_reg;
   assign mdio_wdata = r_mdio_wdata;
   assign link_up    = r_link_up;
   assign cfg_done   = r_cfg_done;
   assign err        = r_err;

endmodule

// File: tb/tb_phy_mgmt_sched.sv
// -----------------------------------------------------------------------------
// tb_phy_mgmt_sched
//
// Purpose:
//   Directed testbench for phy_mgmt_sched, run with short phase lengths.
//   It covers:
//     - reset values;
//     - the reset hold and settle timing;
//     - the four configuration writes;
//     - round-robin polling and link status;
//     - ack arriving on the timeout cycle;
//     - a real timeout;
//     - restart while a request is outstanding;
//     - restart during the reset hold;
//     - asynchronous reset.
//
// Ports:
//   none (top-level testbench)
// -----------------------------------------------------------------------------
module tb_phy_mgmt_sched;

   localparam int unsigned HOLD = 10;
   localparam int unsigned WAIT = 5;
   localparam int unsigned GAP  = 4;
   localparam int unsigned TMO  = 8;
   localparam int          LIM  = 200;

   logic        clk        = 1'b0;
   logic        rst_n      = 1'b0;
   logic        restart    = 1'b0;
   logic        mdio_ack   = 1'b0;
   logic [15:0] mdio_rdata = 16'h0000;
   logic        phy_rst_n;
   logic        mdio_req;
   logic        mdio_rd;
   logic [4:0]  mdio_phy;
   logic [4:0]  mdio_reg;
   logic [15:0] mdio_wdata;
   logic [3:0]  link_up;
   logic        cfg_done;
   logic        err;

   int errors = 0;
   int checks = 0;

   phy_mgmt_sched #(
      .RST_HOLD_CYC (HOLD),
      .RST_WAIT_CYC (WAIT),
      .POLL_GAP_CYC (GAP),
      .TIMEOUT_CYC  (TMO)
   ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .restart    (restart),
      .phy_rst_n  (phy_rst_n),
      .mdio_req   (mdio_req),
      .mdio_rd    (mdio_rd),
      .mdio_phy   (mdio_phy),
      .mdio_reg   (mdio_reg),
      .mdio_wdata (mdio_wdata),
      .mdio_ack   (mdio_ack),
      .mdio_rdata (mdio_rdata),
      .link_up    (link_up),
      .cfg_done   (cfg_done),
      .err        (err)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   // Called at a negedge. Counts samples with mdio_req low, including the current one.
   task automatic wait_req(output int lows);
      lows = 0;
      while (mdio_req !== 1'b1 && lows < LIM) begin
         lows++;
         @(negedge clk);
      end
   endtask

   // Called at the first negedge with mdio_req high.
   // Waits 'delay' cycles, recording whether the request held steady, then pulses ack.
   // Returns at the negedge following the ack edge.
   task automatic ack_after(input int delay, input logic [15:0] rdata, output bit stable);
      logic [26:0] snap;
      snap   = {mdio_rd, mdio_phy, mdio_reg, mdio_wdata};
      stable = 1'b1;
      repeat (delay) begin
         @(negedge clk);
         if (mdio_req !== 1'b1 || {mdio_rd, mdio_phy, mdio_reg, mdio_wdata} !== snap)
            stable = 1'b0;
      end
      mdio_ack   = 1'b1;
      mdio_rdata = rdata;
      @(posedge clk);
      #1;
      mdio_ack   = 1'b0;
      mdio_rdata = 16'h0000;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({phy_rst_n, mdio_req, mdio_rd, mdio_phy, mdio_reg, mdio_wdata, link_up, cfg_done, err}
          !== 36'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %b/%b/%b/%h/%h/%h/%b/%b/%b want all zero",
                  phy_rst_n, mdio_req, mdio_rd, mdio_phy, mdio_reg, mdio_wdata, link_up,
                  cfg_done, err);
      end
   endtask

   task automatic test_hold_wait;
      int lows;
      @(negedge clk);
      rst_n = 1'b1;
      lows  = 0;
      while (phy_rst_n === 1'b0 && lows < LIM) begin
         lows++;
         @(negedge clk);
      end
      checks++;
      if (lows !== HOLD) begin
         errors++;
         $display("FAIL hold_len: got %0d want %0d", lows, HOLD);
      end
      wait_req(lows);
      checks++;
      if (lows !== WAIT + 1) begin
         errors++;
         $display("FAIL wait_len: got %0d want %0d", lows, WAIT + 1);
      end
      checks++;
      if (phy_rst_n !== 1'b1) begin
         errors++;
         $display("FAIL phy_rst_released: got %b want 1", phy_rst_n);
      end
   endtask

   task automatic test_cfg;
      int lows;
      bit stable;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            wait_req(lows);
            checks++;
            if (lows !== 1) begin
               errors++;
               $display("FAIL cfg_gap%0d: got %0d want 1", i, lows);
            end
         end
         checks++;
         if ({mdio_rd, mdio_phy, mdio_reg, mdio_wdata} !== {1'b0, 5'(i), 5'd20, 16'h0CE2}) begin
            errors++;
            $display("FAIL cfg_txn%0d: got rd=%b phy=%0d reg=%0d wd=%h want rd=0 phy=%0d reg=20 wd=0ce2",
                     i, mdio_rd, mdio_phy, mdio_reg, mdio_wdata, i);
         end
         checks++;
         if (cfg_done !== 1'b0) begin
            errors++;
            $display("FAIL cfg_done_early%0d: got %b want 0", i, cfg_done);
         end
         ack_after(3, 16'h0000, stable);
         checks++;
         if (!stable || mdio_req !== 1'b0) begin
            errors++;
            $display("FAIL cfg_hs%0d: stable=%b req=%b want stable=1 req=0", i, stable, mdio_req);
         end
      end
      checks++;
      if (cfg_done !== 1'b1) begin
         errors++;
         $display("FAIL cfg_done: got %b want 1", cfg_done);
      end
   endtask

   task automatic test_poll;
      logic [4:0]  exp_phy  [9] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0};
      logic [15:0] rd_val   [9] = '{16'h0000, 16'h0000, 16'h0004, 16'h0000, 16'h0000,
                                    16'h0004, 16'h0004, 16'hFFFB, 16'h0000};
      int          dly      [9] = '{3, 3, 3, 3, 3, 7, 3, 3, 3};
      logic [3:0]  exp_link [9] = '{4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0100,
                                    4'b0110, 4'b0110, 4'b0110, 4'b0110};
      int lows;
      bit stable;
      for (int i = 0; i < 9; i++) begin
         wait_req(lows);
         checks++;
         if (lows !== GAP + 1) begin
            errors++;
            $display("FAIL poll_gap%0d: got %0d want %0d", i, lows, GAP + 1);
         end
         checks++;
         if ({mdio_rd, mdio_phy, mdio_reg} !== {1'b1, exp_phy[i], 5'd1}) begin
            errors++;
            $display("FAIL poll_txn%0d: got rd=%b phy=%0d reg=%0d want rd=1 phy=%0d reg=1",
                     i, mdio_rd, mdio_phy, mdio_reg, exp_phy[i]);
         end
         ack_after(dly[i], rd_val[i], stable);
         checks++;
         if (!stable || mdio_req !== 1'b0) begin
            errors++;
            $display("FAIL poll_hs%0d: stable=%b req=%b want stable=1 req=0", i, stable, mdio_req);
         end
         checks++;
         if (link_up !== exp_link[i] || err !== 1'b0) begin
            errors++;
            $display("FAIL poll_link%0d: got link=%b err=%b want link=%b err=0",
                     i, link_up, err, exp_link[i]);
         end
      end
   endtask

   task automatic test_timeout;
      int lows;
      int hi;
      wait_req(lows);
      checks++;
      if (lows !== GAP + 1 || mdio_phy !== 5'd1) begin
         errors++;
         $display("FAIL tmo_start: got gap=%0d phy=%0d want gap=%0d phy=1", lows, mdio_phy, GAP + 1);
      end
      hi = 0;
      while (mdio_req === 1'b1 && hi < LIM) begin
         hi++;
         @(negedge clk);
      end
      checks++;
      if (hi !== TMO) begin
         errors++;
         $display("FAIL tmo_len: got %0d want %0d", hi, TMO);
      end
      checks++;
      if (err !== 1'b1 || link_up !== 4'b0100) begin
         errors++;
         $display("FAIL tmo_flags: got err=%b link=%b want err=1 link=0100", err, link_up);
      end
      wait_req(lows);
      checks++;
      if (lows !== GAP + 1 || mdio_phy !== 5'd2 || mdio_rd !== 1'b1) begin
         errors++;
         $display("FAIL tmo_next: got gap=%0d phy=%0d rd=%b want gap=%0d phy=2 rd=1",
                  lows, mdio_phy, mdio_rd, GAP + 1);
      end
   endtask

   task automatic test_restart;
      int lows;
      // A read of PHY 2 is outstanding here.
      restart = 1'b1;
      @(posedge clk);
      #1;
      restart = 1'b0;
      @(negedge clk);
      checks++;
      if ({mdio_req, phy_rst_n, link_up, cfg_done, err} !== {1'b0, 1'b0, 4'b0000, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL restart_out: got req=%b rst=%b link=%b done=%b err=%b want 0/0/0000/0/1",
                  mdio_req, phy_rst_n, link_up, cfg_done, err);
      end
      mdio_ack   = 1'b1;
      mdio_rdata = 16'h0004;
      @(posedge clk);
      #1;
      mdio_ack   = 1'b0;
      mdio_rdata = 16'h0000;
      @(negedge clk);
      checks++;
      if ({mdio_req, phy_rst_n, link_up, err} !== {1'b0, 1'b0, 4'b0000, 1'b1}) begin
         errors++;
         $display("FAIL late_ack: got req=%b rst=%b link=%b err=%b want 0/0/0000/1",
                  mdio_req, phy_rst_n, link_up, err);
      end
      repeat (2) @(negedge clk);
      // A second restart part-way through the hold must restart the hold count.
      restart = 1'b1;
      @(posedge clk);
      #1;
      restart = 1'b0;
      @(negedge clk);
      lows = 0;
      while (phy_rst_n === 1'b0 && lows < LIM) begin
         lows++;
         @(negedge clk);
      end
      checks++;
      if (lows !== HOLD) begin
         errors++;
         $display("FAIL rehold_len: got %0d want %0d", lows, HOLD);
      end
   endtask

   task automatic test_async_reset;
      int lows;
      wait_req(lows);
      checks++;
      if (lows !== WAIT + 1 || mdio_phy !== 5'd0 || mdio_rd !== 1'b0) begin
         errors++;
         $display("FAIL recfg_start: got wait=%0d phy=%0d rd=%b want wait=%0d phy=0 rd=0",
                  lows, mdio_phy, mdio_rd, WAIT + 1);
      end
      // Assert reset away from any clock edge and check before the next posedge.
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({phy_rst_n, mdio_req, mdio_rd, mdio_phy, mdio_reg, mdio_wdata, link_up, cfg_done, err}
          !== 36'd0) begin
         errors++;
         $display("FAIL async_reset: got %b/%b/%b/%h/%h/%h/%b/%b/%b want all zero",
                  phy_rst_n, mdio_req, mdio_rd, mdio_phy, mdio_reg, mdio_wdata, link_up,
                  cfg_done, err);
      end
   endtask

   initial begin
      test_reset();
      test_hold_wait();
      test_cfg();
      test_poll();
      test_timeout();
      test_restart();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/phy_mgmt_sched.md
PHY_MGMT_SCHED -- requirements
Module: phy_mgmt_sched

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- RST_HOLD_CYC, 1250000, cycles phy_rst_n is held low (10 ms at 125 MHz).
- RST_WAIT_CYC, 625000, cycles waited after reset release before the first MDIO access.
- POLL_GAP_CYC, 12500, idle cycles between status polls.
- TIMEOUT_CYC, 65535, maximum cycles to wait for mdio_ack.
- PHY_ADDR_BASE, 5'd0, MDIO address of port 0; port i uses PHY_ADDR_BASE+i (mod 32).
- CFG_REG, 5'd20, PHY register written during configuration.
- CFG_DATA, 16'h0CE2, value written to CFG_REG (RGMII RX/TX delay enable).
- STAT_REG, 5'd1, PHY status register polled.
- LINK_BIT, 2, bit index of link status in STAT_REG.
REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock.
- rst_n, in, 1, asynchronous active-low reset.
- restart, in, 1, single-cycle pulse that re-runs the full sequence.
- phy_rst_n, out, 1, shared PHY hardware reset, active low.
- mdio_req, out, 1, transaction request to the MDIO engine.
- mdio_rd, out, 1, 1 = read, 0 = write.
- mdio_phy, out, 5, PHY address.
- mdio_reg, out, 5, register address.
- mdio_wdata, out, 16, write data.
- mdio_ack, in, 1, single-cycle completion pulse from the engine.
- mdio_rdata, in, 16, read data, valid when mdio_ack=1.
- link_up, out, 4, per-port link status.
- cfg_done, out, 1, high once all 4 configuration writes have completed.
- err, out, 1, sticky flag: at least one transaction timed out.

Function
REQ-003 SHALL implement states RST_HOLD, RST_WAIT, CFG, POLL_GAP, POLL with a 2-bit port index.
REQ-004 RST_HOLD SHALL drive phy_rst_n=0 for exactly RST_HOLD_CYC cycles, then go to RST_WAIT.
REQ-005 RST_WAIT SHALL drive phy_rst_n=1 for RST_WAIT_CYC cycles, then go to CFG with port=0.
REQ-006 CFG SHALL issue a write of CFG_DATA to CFG_REG at PHY_ADDR_BASE+port.
- After ack or timeout: increment port.
- After port 3: set cfg_done=1, set port=0, go to POLL_GAP.
REQ-007 POLL_GAP SHALL idle for POLL_GAP_CYC cycles, then go to POLL.
REQ-008 POLL SHALL issue a read of STAT_REG at PHY_ADDR_BASE+port.
- On ack: link_up[port] <= mdio_rdata[LINK_BIT].
- Then port <= port+1 (wraps 3->0) and go to POLL_GAP.
REQ-009 Handshake SHALL work as follows:
- mdio_req rises one cycle after entering CFG/POLL.
- mdio_rd, mdio_phy, mdio_reg and mdio_wdata hold stable while mdio_req=1.
- mdio_req falls in the cycle after mdio_ack is sampled high.
- At least one mdio_req=0 cycle separates consecutive requests.
REQ-010 mdio_ack received while no request is outstanding SHALL be ignored.
REQ-011 A timeout counter SHALL count cycles with mdio_req=1 and reset at each new request. On reaching TIMEOUT_CYC without ack:
- drop mdio_req;
- set err=1;
- in POLL, set link_up[port]=0;
- advance exactly as if ack had arrived.
REQ-012 mdio_ack and timeout in the same cycle SHALL be treated as ack; err is not set.
REQ-013 restart=1 in any state SHALL, on the next cycle:
- enter RST_HOLD with counters cleared;
- drop mdio_req and abandon any outstanding transaction;
- clear link_up and cfg_done (err retained).
REQ-014 restart during RST_HOLD SHALL restart the hold count from zero.
REQ-015 Internal cycle counters SHALL be wide enough for the largest parameter and SHALL NOT wrap.

Reset
REQ-016 While rst_n=0, outputs SHALL be: phy_rst_n=0, mdio_req=0, mdio_rd=0, mdio_phy=0, mdio_reg=0, mdio_wdata=0, link_up=0, cfg_done=0, err=0; state=RST_HOLD, port=0, all counters 0.
REQ-017 After rst_n deasserts, the sequence SHALL start automatically; no restart pulse is required.

Verification (RST_HOLD_CYC=10, RST_WAIT_CYC=5, POLL_GAP_CYC=4, TIMEOUT_CYC=8)
REQ-018 Release rst_n -> phy_rst_n low for exactly 10 cycles, then high; first mdio_req appears after 5 wait cycles (+1 cycle).
REQ-019 Ack every request after 3 cycles -> 4 writes of 16'h0CE2 to reg 20 at PHY 0..3 in order; cfg_done rises after the 4th ack; reads of reg 1 follow at PHY 0,1,2,3,0 with 4-cycle gaps.
REQ-020 Return rdata=16'h0004 for PHY 2 only -> link_up=4'b0100.
REQ-021 Never ack PHY 1 read -> mdio_req drops after 8 cycles, err=1, link_up[1]=0, next read targets PHY 2.
REQ-022 Pulse restart mid-poll with a request outstanding -> next cycle mdio_req=0, phy_rst_n=0, link_up=0, cfg_done=0, err unchanged; a late ack is ignored.
REQ-023 Assert rst_n=0 mid-CFG -> all outputs take reset values asynchronously (no clock edge required).
